seg_value_sched: RTL
====================

SEG_VALUE_SCHED -- requirements
Module: seg_value_sched

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 24'd12_000_000, giving the alert display duration in clocks.
REQ-002 The block SHALL have parameter BLINK_HALF, default 24'd3_000_000, giving the alert blink half-period in clocks.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 24'd1_200_000, giving the blank gap after an alert in clocks.
REQ-004 The block SHALL have parameter STALE_CYCLES, default 28'd36_000_000, giving the heart-rate staleness timeout in clocks.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port hr_valid, input, 1 bit: one-cycle strobe marking a new heart-rate sample.
REQ-008 The block SHALL have port hr_value, input, 8 bits: heart-rate sample, sampled when hr_valid=1.
REQ-009 The block SHALL have port alert_req, input, 1 bit: level request to show an alert code.
REQ-010 The block SHALL have port alert_code, input, 8 bits: alert code, sampled on acceptance.
REQ-011 The block SHALL have port alert_ack, output, 1 bit: one-cycle pulse when an alert is accepted.
REQ-012 The block SHALL have port value_out, output, 8 bits: value to the two-digit hex segment decoder.
REQ-013 The block SHALL have port blank_out, output, 1 bit: 1 = display must be blanked.
REQ-014 The block SHALL have port src_out, output, 2 bits: current source (0 none, 1 heart rate, 2 alert, 3 gap).

Function
REQ-015 The block SHALL implement states IDLE, SHOW_HR, ALERT and GAP, and src_out SHALL encode the state as 0, 1, 2 and 3 respectively.
REQ-016 On every hr_valid=1, in any state, the block SHALL latch hr_value into hr_reg, set hr_seen=1 and clear the stale counter.
REQ-017 IDLE: value_out SHALL be 8'hFF and blank_out SHALL be 1; hr_valid SHALL move the block to SHOW_HR on the next cycle.
REQ-018 SHOW_HR: value_out SHALL equal hr_reg and blank_out SHALL be 0; a new hr_valid SHALL be reflected on value_out one cycle later.
REQ-019 SHOW_HR: the stale counter SHALL increment each cycle without hr_valid; on reaching STALE_CYCLES-1 the block SHALL enter IDLE and clear hr_seen.
REQ-020 In IDLE or SHOW_HR, alert_req=1 SHALL latch alert_code, pulse alert_ack for exactly one cycle, and enter ALERT on the next cycle.
REQ-021 In ALERT, GAP or the cycle after acceptance, alert_req SHALL be ignored and no alert_ack SHALL be issued; the requester holds alert_req until it is acked.
REQ-022 If alert_req and hr_valid arrive in the same cycle, the alert SHALL be accepted and the heart-rate sample SHALL still be latched per REQ-016.
REQ-023 ALERT: value_out SHALL equal the latched code.
REQ-024 ALERT: blank_out SHALL start at 0 and toggle every BLINK_HALF cycles.
REQ-025 ALERT: the hold counter SHALL run from 0; at HOLD_CYCLES-1 the block SHALL enter GAP.
REQ-026 The stale counter SHALL freeze during ALERT and GAP.
REQ-027 GAP: value_out SHALL be 8'hFF and blank_out SHALL be 1 for GAP_CYCLES cycles.
REQ-028 At the end of GAP the block SHALL enter SHOW_HR if hr_seen=1, otherwise IDLE.
REQ-029 All outputs SHALL be registered, with one cycle of latency from the state/input decision.
REQ-030 Counters SHALL saturate at their terminal values and never wrap.
REQ-031 Parameter values of 0 SHALL be treated as 1.

Reset
REQ-032 While rst_n=0, the block SHALL hold state IDLE, value_out=8'hFF, blank_out=1, src_out=0, alert_ack=0, hr_reg=0, hr_seen=0, all counters 0.
REQ-033 Reset asserted mid-ALERT or mid-GAP SHALL abort immediately with no further alert_ack, and the latched code SHALL be discarded.

Verification
REQ-034 (HOLD=8, BLINK_HALF=2, GAP=2, STALE=16 for all scenarios.) Bench SHALL cover: reset released, no stimulus -> value_out=FF, blank_out=1, src_out=0 indefinitely.
REQ-035 Bench SHALL cover: hr_valid with hr_value=8'h48 -> next cycle src_out=1, value_out=48, blank_out=0; no further hr_valid -> IDLE after 16 cycles.
REQ-036 Bench SHALL cover: in SHOW_HR(48), alert_req with code 8'hE1 -> one alert_ack pulse; value_out=E1 for 8 cycles with blank pattern 0,0,1,1,0,0,1,1; then 2 gap cycles (FF, blank); then value_out=48.
REQ-037 Bench SHALL cover: second alert_req held high during ALERT -> no ack until after GAP; accepted on the first SHOW_HR cycle.
REQ-038 Bench SHALL cover: hr_valid(8'h50) and alert_req(8'hC3) in the same cycle from IDLE -> alert shown first, then SHOW_HR with value_out=50.
REQ-039 Bench SHALL cover: rst_n pulsed low at hold cycle 4 -> outputs return to reset values asynchronously, with no alert_ack afterward.

Source files
------------

// File: rtl/seg_value_sched.sv
// rtl/seg_value_sched.sv - display value scheduler: heart rate, blinking alert codes, blank gap
// Outputs are registered from next-state values, so they change on the same edge as the state.
module seg_value_sched #(
   parameter logic [23:0] HOLD_CYCLES  = 24'd12_000_000,
   parameter logic [23:0] BLINK_HALF   = 24'd3_000_000,
   parameter logic [23:0] GAP_CYCLES   = 24'd1_200_000,
   parameter logic [27:0] STALE_CYCLES = 28'd36_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       hr_valid,
   input  logic [7:0] hr_value,
   input  logic       alert_req,
   input  logic [7:0] alert_code,
   output logic       alert_ack,
   output logic [7:0] value_out,
   output logic       blank_out,
   output logic [1:0] src_out
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SHOW_HR = 2'd1,
      S_ALERT   = 2'd2,
      S_GAP     = 2'd3
   } state_t;

   // A zero parameter behaves as one: its terminal count collapses to 0.
   localparam logic [23:0] HOLD_LAST  = (HOLD_CYCLES  == 24'd0) ? 24'd0 : HOLD_CYCLES  - 24'd1;
   localparam logic [23:0] BLINK_LAST = (BLINK_HALF   == 24'd0) ? 24'd0 : BLINK_HALF   - 24'd1;
   localparam logic [23:0] GAP_LAST   = (GAP_CYCLES   == 24'd0) ? 24'd0 : GAP_CYCLES   - 24'd1;
   localparam logic [27:0] STALE_LAST = (STALE_CYCLES == 28'd0) ? 28'd0 : STALE_CYCLES - 28'd1;

   state_t      state_q, state_d;
   logic [7:0]  hr_q, hr_d;
   logic        hr_seen_q, hr_seen_d;
   logic [7:0]  code_q, code_d;
   logic [27:0] stale_q, stale_d;
   logic [23:0] hold_q, hold_d;
   logic [23:0] blink_q, blink_d;
   logic [23:0] gap_q, gap_d;
   logic        ack_q, ack_d;
   logic [7:0]  value_q, value_d;
   logic        blank_q, blank_d;
   logic [1:0]  src_q, src_d;
   logic        accept;
   logic        blink_flip;

   always_comb begin
      state_d    = state_q;
      hr_d       = hr_q;
      hr_seen_d  = hr_seen_q;
      code_d     = code_q;
      stale_d    = stale_q;
      hold_d     = hold_q;
      blink_d    = blink_q;
      gap_d      = gap_q;
      ack_d      = 1'b0;
      blink_flip = 1'b0;
      accept     = alert_req && (state_q == S_IDLE || state_q == S_SHOW_HR);

      if (hr_valid) begin
         hr_d      = hr_value;
         hr_seen_d = 1'b1;
         stale_d   = 28'd0;
      end

      case (state_q)
         S_IDLE: begin
            if (hr_valid) state_d = S_SHOW_HR;
         end
         S_SHOW_HR: begin
            if (!hr_valid) begin
               if (stale_q == STALE_LAST) begin
                  hr_seen_d = 1'b0;
                  stale_d   = 28'd0;
                  state_d   = S_IDLE;
               end else begin
                  stale_d = stale_q + 28'd1;
               end
            end
         end
         S_ALERT: begin
            if (hold_q == HOLD_LAST) begin
               state_d = S_GAP;
               gap_d   = 24'd0;
            end else begin
               hold_d = hold_q + 24'd1;
               if (blink_q == BLINK_LAST) begin
                  blink_d    = 24'd0;
                  blink_flip = 1'b1;
               end else begin
                  blink_d = blink_q + 24'd1;
               end
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) state_d = hr_seen_d ? S_SHOW_HR : S_IDLE;
            else                   gap_d   = gap_q + 24'd1;
         end
         default: state_d = S_IDLE;
      endcase

      // Alert acceptance overrides both the heart-rate entry and the stale timeout.
      if (accept) begin
         state_d = S_ALERT;
         code_d  = alert_code;
         ack_d   = 1'b1;
         hold_d  = 24'd0;
         blink_d = 24'd0;
      end

      value_d = 8'hFF;
      blank_d = 1'b1;
      case (state_d)
         S_SHOW_HR: begin
            value_d = hr_d;
            blank_d = 1'b0;
         end
         S_ALERT: begin
            value_d = code_d;
            blank_d = (state_q != S_ALERT) ? 1'b0 : (blank_q ^ blink_flip);
         end
         default: ;
      endcase
      src_d = state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         hr_q      <= 8'h00;
         hr_seen_q <= 1'b0;
         code_q    <= 8'h00;
         stale_q   <= 28'd0;
         hold_q    <= 24'd0;
         blink_q   <= 24'd0;
         gap_q     <= 24'd0;
         ack_q     <= 1'b0;
         value_q   <= 8'hFF;
         blank_q   <= 1'b1;
         src_q     <= 2'd0;
      end else begin
         state_q   <= state_d;
         hr_q      <= hr_d;
         hr_seen_q <= hr_seen_d;
         code_q    <= code_d;
         stale_q   <= stale_d;
         hold_q    <= hold_d;
         blink_q   <= blink_d;
         gap_q     <= gap_d;
         ack_q     <= ack_d;
         value_q   <= value_d;
         blank_q   <= blank_d;
         src_q     <= src_d;
      end
   end

   assign alert_ack = ack_q;
   assign value_out = value_q;
   assign blank_out = blank_q;
   assign src_out   = src_q;

endmodule
